// File: rtl/jtkicker_sndrom_arb.sv
// Sound ROM arbiter: Z80 program and VLM5030 speech data share one
// SDRAM slot through one-byte tagged caches and a round-robin fetcher.
module jtkicker_sndrom_arb #(
  parameter int                CPU_AW     = 13,
  parameter int                PCM_AW     = 16,
  parameter int                ROM_AW     = 17,
  parameter logic [ROM_AW-1:0] PCM_OFFSET = 17'h02000
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic              cpu_cs,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic [PCM_AW-1:0] pcm_addr,
  input  logic              pcm_cs,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT
  } state_t;

  state_t state, state_nxt;

  logic              cpu_valid;
  logic [CPU_AW-1:0] cpu_tag;
  logic              pcm_valid;
  logic [PCM_AW-1:0] pcm_tag;

  logic              last_pcm;
  logic              fetch_pcm;
  logic [CPU_AW-1:0] fetch_cpu_addr;
  logic [PCM_AW-1:0] fetch_pcm_addr;

  logic hit_cpu, hit_pcm;
  logic miss_cpu, miss_pcm;
  logic grant, grant_pcm, fill;
  logic [ROM_AW-1:0] cpu_rom_addr, pcm_rom_addr;

  assign hit_cpu  = cpu_valid & (cpu_tag == cpu_addr);
  assign hit_pcm  = pcm_valid & (pcm_tag == pcm_addr);
  assign cpu_ok   = cpu_cs & hit_cpu;
  assign pcm_ok   = pcm_cs & hit_pcm;
  assign miss_cpu = cpu_cs & ~hit_cpu;
  assign miss_pcm = pcm_cs & ~hit_pcm;

  assign cpu_rom_addr = ROM_AW'(cpu_addr);
  assign pcm_rom_addr = ROM_AW'(pcm_addr) + PCM_OFFSET;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_pcm = 1'b0;
    fill      = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_cpu | miss_pcm) begin
          grant     = 1'b1;
          // on contention the side not served last wins
          grant_pcm = miss_pcm & (~miss_cpu | ~last_pcm);
          state_nxt = SETTLE;
        end
      end
      // rom_ok may still belong to the previous address here
      SETTLE: state_nxt = WAIT;
      WAIT: begin
        if (rom_ok) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs         <= 1'b0;
      rom_addr       <= '0;
      last_pcm       <= 1'b1;
      fetch_pcm      <= 1'b0;
      fetch_cpu_addr <= '0;
      fetch_pcm_addr <= '0;
      cpu_valid      <= 1'b0;
      cpu_tag        <= '0;
      cpu_data       <= '0;
      pcm_valid      <= 1'b0;
      pcm_tag        <= '0;
      pcm_data       <= '0;
    end else begin
      if (grant) begin
        rom_cs    <= 1'b1;
        fetch_pcm <= grant_pcm;
        if (grant_pcm) begin
          fetch_pcm_addr <= pcm_addr;
          rom_addr       <= pcm_rom_addr;
        end else begin
          fetch_cpu_addr <= cpu_addr;
          rom_addr       <= cpu_rom_addr;
        end
      end
      if (fill) begin
        rom_cs   <= 1'b0;
        last_pcm <= fetch_pcm;
        if (fetch_pcm) begin
          pcm_valid <= 1'b1;
          pcm_tag   <= fetch_pcm_addr;
          pcm_data  <= rom_data;
        end else begin
          cpu_valid <= 1'b1;
          cpu_tag   <= fetch_cpu_addr;
          cpu_data  <= rom_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_sndrom_arb.sv
// Bench for jtkicker_sndrom_arb: directed cases plus random traffic
// checked against a cache/fetch reference model.
module tb_jtkicker_sndrom_arb;

  logic        rst, clk;
  logic [12:0] cpu_addr;
  logic        cpu_cs;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic [15:0] pcm_addr;
  logic        pcm_cs;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [16:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;

  logic [12:0] w_cpu_addr;
  logic        w_cpu_cs;
  logic [7:0]  w_cpu_data;
  logic        w_cpu_ok;
  logic [15:0] w_pcm_addr;
  logic        w_pcm_cs;
  logic [7:0]  w_pcm_data;
  logic        w_pcm_ok;
  logic [16:0] w_rom_addr;
  logic        w_rom_cs;
  logic [7:0]  w_rom_data;
  logic        w_rom_ok;

  jtkicker_sndrom_arb u_dut (
    .rst(rst), .clk(clk),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs),
    .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .pcm_addr(pcm_addr), .pcm_cs(pcm_cs),
    .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  jtkicker_sndrom_arb #(.PCM_OFFSET(17'h1F000)) u_wrap (
    .rst(rst), .clk(clk),
    .cpu_addr(w_cpu_addr), .cpu_cs(w_cpu_cs),
    .cpu_data(w_cpu_data), .cpu_ok(w_cpu_ok),
    .pcm_addr(w_pcm_addr), .pcm_cs(w_pcm_cs),
    .pcm_data(w_pcm_data), .pcm_ok(w_pcm_ok),
    .rom_addr(w_rom_addr), .rom_cs(w_rom_cs),
    .rom_data(w_rom_data), .rom_ok(w_rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  logic [7:0] rom_mem [0:131071];

  bit         m_valid [2];
  int         m_tag   [2];
  logic [7:0] m_data  [2];
  bit         m_active;
  bit         m_who;
  int         m_addr;
  int         m_age;
  bit         m_last;
  int         lat, wait_cnt, fixed_lat;
  bit         prev_rom_cs;
  bit         dut_grants [$];

  function automatic logic [16:0] map_addr(input bit who, input int a);
    return who ? 17'(a + 32'h2000) : 17'(a);
  endfunction

  function automatic bit exp_ok(input bit who);
    if (who) return pcm_cs && m_valid[1] && m_tag[1] == int'(pcm_addr);
    return cpu_cs && m_valid[0] && m_tag[0] == int'(cpu_addr);
  endfunction

  task automatic model_reset();
    m_valid  = '{0, 0};
    m_tag    = '{0, 0};
    m_data   = '{8'h00, 8'h00};
    m_active = 0;
    m_age    = 0;
    m_last   = 1;
    prev_rom_cs = 0;
  endtask

  task automatic model_update();
    bit mc, mp;
    mc = cpu_cs && !(m_valid[0] && m_tag[0] == int'(cpu_addr));
    mp = pcm_cs && !(m_valid[1] && m_tag[1] == int'(pcm_addr));
    if (!m_active) begin
      if (mc || mp) begin
        m_who    = (mc && mp) ? !m_last : mp;
        m_addr   = m_who ? int'(pcm_addr) : int'(cpu_addr);
        m_active = 1;
        m_age    = 0;
        lat      = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
        wait_cnt = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rom_ok) begin
      m_valid[m_who] = 1;
      m_tag[m_who]   = m_addr;
      m_data[m_who]  = rom_mem[map_addr(m_who, m_addr)];
      m_last         = m_who;
      m_active       = 0;
    end
  endtask

  task automatic check_all();
    chk("rom_cs", rom_cs, m_active);
    if (m_active) chk("rom_addr", rom_addr, map_addr(m_who, m_addr));
    chk("cpu_ok", cpu_ok, exp_ok(0));
    chk("pcm_ok", pcm_ok, exp_ok(1));
    chk("cpu_data", cpu_data, m_data[0]);
    chk("pcm_data", pcm_data, m_data[1]);
    if (!prev_rom_cs && rom_cs) dut_grants.push_back(rom_addr >= 17'h2000);
    prev_rom_cs = rom_cs;
  endtask

  task automatic drive_rom();
    if (m_active && m_age == 0) begin
      rom_ok   = 1;
      rom_data = ~rom_mem[map_addr(m_who, m_addr)];
    end else if (m_active) begin
      rom_ok   = wait_cnt >= lat;
      rom_data = rom_ok ? rom_mem[map_addr(m_who, m_addr)] : 8'($urandom);
      wait_cnt++;
    end else begin
      rom_ok   = 1'($urandom_range(0, 1));
      rom_data = 8'($urandom);
    end
  endtask

  task automatic tick();
    #1;
    chk("cpu_ok_comb", cpu_ok, exp_ok(0));
    chk("pcm_ok_comb", pcm_ok, exp_ok(1));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    drive_rom();
  endtask

  task automatic do_reset();
    rst = 1; cpu_cs = 1; pcm_cs = 1; rom_ok = 0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_cpu_ok", cpu_ok, 0);
    chk("rst_pcm_ok", pcm_ok, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_pcm_data", pcm_data, 0);
    rst = 0; cpu_cs = 0; pcm_cs = 0;
  endtask

  task automatic wait_in_wait();
    int n = 0;
    while (!(m_active && m_age >= 1)) begin
      if (n++ > 50) begin chk("timeout_wait", 1, 0); return; end
      tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_active) begin
      if (n++ > 50) begin chk("timeout_idle", 1, 0); return; end
      tick();
    end
  endtask

  int cpu_set [4] = '{32'h0000, 32'h1FFF, 32'h0100, 32'h0ABC};
  int pcm_set [4] = '{32'h0000, 32'hFFFF, 32'h0010, 32'h1234};

  initial begin
    for (int i = 0; i < 131072; i++) rom_mem[i] = 8'($urandom);
    rom_mem[17'h00100] = 8'hA5;
    rst = 1; cpu_addr = 0; pcm_addr = 0; rom_data = 0; rom_ok = 0;
    w_cpu_addr = 0; w_cpu_cs = 0; w_pcm_addr = 16'hFFFF; w_pcm_cs = 1;
    w_rom_data = 0; w_rom_ok = 0;
    fixed_lat = 2;

    do_reset();
    cpu_addr = 13'h0100; cpu_cs = 1;
    tick();
    chk("t1_rom_cs", rom_cs, 1);
    chk("t1_rom_addr", rom_addr, 17'h00100);
    wait_idle();
    chk("t1_cpu_ok", cpu_ok, 1);
    chk("t1_cpu_data", cpu_data, 8'hA5);
    chk("t1_rom_cs0", rom_cs, 0);
    repeat (3) tick();
    chk("t1_hold_ok", cpu_ok, 1);
    chk("t1_no_refetch", rom_cs, 0);

    pcm_addr = 16'h0010; pcm_cs = 1;
    tick();
    chk("t2_pcm_addr", rom_addr, 17'h02010);
    wait_idle();
    chk("t2_pcm_ok", pcm_ok, 1);
    chk("wrap_cs", w_rom_cs, 1);
    chk("wrap_addr", w_rom_addr, 17'(32'h1F000 + 32'hFFFF));

    do_reset();
    fixed_lat = -1;
    cpu_addr = 13'h0300; pcm_addr = 16'h0300; cpu_cs = 1; pcm_cs = 1;
    dut_grants.delete();
    for (int n = 0; n < 300 && dut_grants.size() < 6; n++) begin
      tick();
      if (m_valid[0] && m_tag[0] == int'(cpu_addr)) cpu_addr++;
      if (m_valid[1] && m_tag[1] == int'(pcm_addr)) pcm_addr++;
    end
    chk("alt_count", dut_grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++)
      chk($sformatf("alt_grant%0d", i), dut_grants[i], i % 2);
    wait_idle();

    do_reset();
    fixed_lat = 1;
    cpu_addr = 13'h0200; cpu_cs = 1;
    wait_in_wait();
    cpu_addr = 13'h0201;
    wait_idle();
    chk("mid_ok0", cpu_ok, 0);
    tick();
    chk("mid_refetch_cs", rom_cs, 1);
    chk("mid_refetch_addr", rom_addr, 17'h00201);
    wait_idle();
    chk("mid_ok1", cpu_ok, 1);

    fixed_lat = 6;
    pcm_addr = 16'h4444; pcm_cs = 1;
    wait_in_wait();
    chk("other_hit_ok", cpu_ok, 1);
    rst = 1;
    #1;
    chk("rstw_rom_cs", rom_cs, 0);
    chk("rstw_cpu_ok", cpu_ok, 0);
    chk("rstw_pcm_ok", pcm_ok, 0);
    @(negedge clk);

    do_reset();
    fixed_lat = -1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3) cpu_addr = 13'(cpu_set[$urandom_range(0, 3)]);
      if ($urandom_range(0, 9) < 3) pcm_addr = 16'(pcm_set[$urandom_range(0, 3)]);
      if ($urandom_range(0, 9) < 3) cpu_cs = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) < 3) pcm_cs = $urandom_range(0, 3) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtkicker_sndrom_arb.md
Name: jtkicker_sndrom_arb

Overview:
Shares one byte-wide SDRAM ROM slot between the sound Z80 program fetch and the VLM5030 speech-data fetch on the sound board. Each requester has a one-byte tagged cache, and misses are serialised through a small state machine with round-robin priority. The block sits between the sound subsystem's rom/pcm ports and the game's SDRAM ROM slot.

Parameters:
CPU_AW, 13, CPU ROM address width
PCM_AW, 16, speech data address width
ROM_AW, 17, shared ROM slot address width
PCM_OFFSET, 17'h02000, base of the speech region in the ROM slot

Ports:
rst  input  1  asynchronous reset, active-high
clk  input  1  system clock
cpu_addr  input  CPU_AW  Z80 ROM address
cpu_cs  input  1  Z80 ROM request
cpu_data  output  8  Z80 ROM data
cpu_ok  output  1  cpu_data is valid for cpu_addr
pcm_addr  input  PCM_AW  VLM5030 data address
pcm_cs  input  1  VLM5030 data request
pcm_data  output  8  VLM5030 data
pcm_ok  output  1  pcm_data is valid for pcm_addr
rom_addr  output  ROM_AW  shared slot address, registered
rom_cs  output  1  shared slot request, registered
rom_data  input  8  shared slot data
rom_ok  input  1  shared slot data valid

Behaviour:
- Reset is rst, asynchronous and active-high; clock is clk.
- Reset values:
  - rom_cs=0, rom_addr=0.
  - cpu_data=0, pcm_data=0.
  - Both cache valid bits = 0, so cpu_ok=0 and pcm_ok=0.
  - State=IDLE, last-served flag=PCM, which gives the CPU first priority.
- Per-requester cache: valid bit, tag (full requester address width), data byte.
- Hit definitions:
  - hit_cpu = valid_cpu & tag_cpu==cpu_addr.
  - hit_pcm = valid_pcm & tag_pcm==pcm_addr.
- Outputs:
  - cpu_ok = cpu_cs & hit_cpu; pcm_ok = pcm_cs & hit_pcm. Both are combinational from registers and inputs.
  - cpu_data and pcm_data always present the cached byte.
- Pending requests: miss_cpu = cpu_cs & ~hit_cpu; miss_pcm = pcm_cs & ~hit_pcm.
- Address mapping:
  - CPU request: rom_addr = zero-extended cpu_addr.
  - PCM request: rom_addr = PCM_OFFSET + zero-extended pcm_addr. Sum is modulo 2^ROM_AW (wraps).
- State machine:
  - IDLE:
    - If only one requester misses, grant it.
    - If both miss, grant the requester that was not served last.
    - On grant: latch requester id and address into fetch registers, drive rom_addr, set rom_cs=1, go to SETTLE.
    - No miss: stay in IDLE, rom_cs=0.
  - SETTLE: one cycle. rom_ok is ignored here because it may reflect the previous address. Go to WAIT.
  - WAIT:
    - Hold rom_cs=1 and rom_addr stable.
    - On rom_ok=1: write rom_data into the granted cache, set tag = latched address, valid=1, update last-served, clear rom_cs, go to IDLE.
- Latency:
  - Miss seen at edge N: rom_cs=1 after edge N+1.
  - rom_ok at cycle M (M ≥ N+2): ok visible after edge M+1.
  - Minimum miss-to-ok is 3 cycles.
  - A hit gives ok in the same cycle.
- Requester changes mid-fetch: if its address changes or cs drops during SETTLE/WAIT, the fetch still completes. The cache is filled with the latched address; IDLE then re-evaluates, and the new address misses and is fetched.
- Simultaneous events: the cache of the non-granted requester is never modified during a fetch. If it was hit before, it keeps returning ok while the other requester fetches.
- No back-to-back starvation: with continuous misses from both requesters, grants strictly alternate.
- Reset mid-fetch: rom_cs drops immediately, caches are invalidated, and the pending fetch is abandoned.
- rom_ok in IDLE is ignored.

Test Plan:
- Reset, then cpu_cs=1, cpu_addr=13'h0100, ROM model returns 8'hA5 with rom_ok 4 cycles after rom_cs → rom_addr=17'h00100, cpu_ok rises one cycle after rom_ok, cpu_data=8'hA5, rom_cs back to 0.
- Same cpu_addr held after the fill → cpu_ok stays 1 and rom_cs stays 0 (hit, no new fetch).
- pcm_cs=1, pcm_addr=16'h0010 → rom_addr=17'h02010. pcm_addr=16'hFFFF with PCM_OFFSET=17'h1F000 → rom_addr=17'h0EFFF (wrap).
- cpu_cs and pcm_cs both missing in the same cycle right after reset → CPU granted first, then PCM. Keep both missing with changing addresses for 6 fetches → grants alternate C,P,C,P,C,P.
- ROM model asserts a stale rom_ok=1 during the SETTLE cycle → ignored; data is captured only on rom_ok in WAIT.
- cpu_addr changes from 13'h0200 to 13'h0201 during WAIT → first fetch completes with tag 13'h0200, cpu_ok=0, a second fetch for 13'h0201 is issued, then cpu_ok=1. Assert rst during WAIT → rom_cs=0, cpu_ok=0 and pcm_ok=0 in the same cycle.
